piso_feeder: RTL
================

Name: piso_feeder

Overview:
- Parallel-in serial-out stage directly upstream of the overlapping-sequence detector/counter.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit at a time on x, the detector's serial input.
- A single holding register double-buffers the input, so consecutive words stream back-to-back with no idle bit between them.
- x is forced to 0 whenever no word is being shifted, so idle time can never complete a pattern.

Parameters:
- WIDTH, 8, bits per input word (>=2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first; 0 = bit 0 first.
- DIV, 1, clock cycles each bit is held on x (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset: rst=0 clears all state immediately.
- in_data  input  WIDTH  word to serialise.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  holding register empty; word accepted when in_valid & in_ready at a rising edge.
- x  output  1  serial bit to the detector, registered.
- x_valid  output  1  x carries a data bit this cycle.
- busy  output  1  shifter active or holding register full.
- word_done  output  1  one-cycle pulse at the end of the last bit period of a word.

Behaviour:
- Reset (rst=0, async) values:
  - x=0, x_valid=0, word_done=0, busy=0, in_ready=1.
  - Holding register empty; state IDLE; bit counter=0; divide counter=0.
- Holding register:
  - in_ready = ~hold_full, combinational from registered state only; no combinational path from in_valid.
  - On accept: hold<=in_data, hold_full<=1.
  - An accept and a transfer from hold to the shifter can never occur on the same edge, because hold_full=1 at a transfer.
- State IDLE:
  - x=0, x_valid=0.
  - If hold_full: load shifter from hold, clear hold_full, go to SHIFT.
  - The first bit appears on x after that edge, so a word accepted at edge N has its first bit on x in the cycle after edge N+1 (2-cycle latency).
- State SHIFT:
  - x = current bit; x_valid=1.
  - Each bit is held exactly DIV cycles using a divide counter 0..DIV-1.
  - At the end of a bit period the shifter advances (left when MSB_FIRST=1, right when 0) and the bit counter increments.
- End of a word (end of the period of bit WIDTH-1):
  - word_done=1 for the following cycle.
  - If hold_full: reload the shifter from hold, clear hold_full, stay in SHIFT. No gap: the next word's first bit follows immediately.
  - Otherwise go to IDLE; x=0 and x_valid=0 from the next cycle.
- busy = (state==SHIFT) | hold_full.
- Counters:
  - Bit counter is $clog2(WIDTH) wide and wraps to 0 at the end of each word.
  - Divide counter wraps at DIV-1; with DIV=1 it is constant 0 and the bit advances every cycle.
- Reset mid-word: the partially shifted word and any held word are discarded. Outputs return to reset values asynchronously; there is no word_done for the aborted word.
- in_valid while in_ready=0: the word is not taken. The source must hold in_data/in_valid stable until accepted.

Test Plan:
- WIDTH=8, MSB_FIRST=1, DIV=1; push 8'hB0 once -> x = 1,0,1,1,0,0,0,0 on 8 consecutive cycles starting 2 cycles after accept; x_valid high exactly 8 cycles; word_done one pulse after bit 7; downstream count goes 0->1.
- Back-to-back: push 8'hBB then 8'h6D with in_valid held -> 16 contiguous x_valid cycles, x = 10111011 01101101; second accept occurs the cycle after the first transfer; word_done pulses twice, 8 cycles apart.
- Backpressure: push 3 words with in_valid held high -> third word stalls with in_ready=0 until the first word's transfer at its end; no word is lost or duplicated; busy stays high until the last bit ends.
- MSB_FIRST=0, push 8'h0D -> x = 1,0,1,1,0,0,0,0.
- DIV=3, push 8'hA5 -> each bit on x for 3 cycles, 24 x_valid cycles, word_done once.
- Assert rst=0 during bit 4 of 8'hFF with a second word held -> x, x_valid, busy drop to 0 asynchronously; in_ready=1; after release, IDLE with x=0 and no residual bits emitted.

Source files
------------

// File: rtl/piso_feeder.sv
// Parallel-in serial-out feeder for the sequence detector. A single holding
// register double-buffers the input so that consecutive words stream out gap-free.
module piso_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int DIV       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int XB = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic [WIDTH-1:0] shreg_adv;

  assign shreg_adv = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  // The shifter is cleared whenever it goes idle, so x reads straight off a flop
  // and is 0 outside a word without any gating.
  assign x        = shreg[XB];
  assign x_valid  = (state == SHIFT);
  assign in_ready = ~hold_full;
  assign busy     = (state == SHIFT) | hold_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      // Accept needs hold empty, transfer needs hold full: never the same edge.
      if (in_valid && !hold_full) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (hold_full) begin
            shreg     <= hold;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        default: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt   <= '0;
              word_done <= 1'b1;
              if (hold_full) begin
                shreg     <= hold;
                hold_full <= 1'b0;
              end else begin
                shreg <= '0;
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg_adv;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule
